// File: rtl/ledmatrix_pkg.sv
// rtl/ledmatrix_pkg.sv - shared types and constants for the LED-matrix scan reader
//
// Holds the scan FSM state encoding, the word/bit geometry of the serial
// column stream and the fixed Avalon byte-enable value.
package ledmatrix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY
  } state_e;

  localparam int BITS_PER_WORD  = 32;
  localparam int PHASES_PER_BIT = 2;

  localparam logic [3:0] AVM_BYTEENABLE = 4'hF;

endpackage

// File: rtl/ledmatrix_scan_reader_if.sv
// rtl/ledmatrix_scan_reader_if.sv - Avalon-MM read bus between scan reader and frame-buffer RAM
//
// Signals: avm_address / avm_chipselect / avm_read / avm_byteenable (master to RAM),
//          avm_readdata (RAM to master, valid one cycle after the read strobe).
// Modports: master (scan reader side), slave (RAM side).
interface ledmatrix_scan_reader_if #(
  parameter int ADDR_W = 16
);
  import ledmatrix_pkg::*;

  logic [ADDR_W-1:0]        avm_address;
  logic                     avm_chipselect;
  logic                     avm_read;
  logic [3:0]               avm_byteenable;
  logic [BITS_PER_WORD-1:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_read,
    output avm_byteenable,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_read,
    input  avm_byteenable,
    output avm_readdata
  );

endinterface

// File: rtl/ledmatrix_shift_out.sv
// rtl/ledmatrix_shift_out.sv - serialises one 32-bit word MSB first onto sdi/sclk
//
// Ports: clk, reset_n (async, active low)
//        load_i  - capture data_i and start shifting (from FSM)
//        data_i  - word to serialise
//        busy_o  - a word is being shifted
//        done_o  - high in the final phase of the last bit
//        sdi_o   - serial data, registered
//        sclk_o  - shift clock, registered, high in the last phase of each bit
module ledmatrix_shift_out
  import ledmatrix_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load_i,
  input  logic [BITS_PER_WORD-1:0] data_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     sdi_o,
  output logic                     sclk_o
);

  localparam int BIT_W   = $clog2(BITS_PER_WORD);
  localparam int PHASE_W = (PHASES_PER_BIT > 1) ? $clog2(PHASES_PER_BIT) : 1;
  localparam logic [BIT_W-1:0]   FIRST_BIT  = BIT_W'(BITS_PER_WORD - 1);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PHASES_PER_BIT - 1);

  logic [BITS_PER_WORD-1:0] sreg_q, sreg_d;
  logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [PHASE_W-1:0]       phase_q, phase_d;
  logic                     busy_q, busy_d;
  logic                     sclk_q, sclk_d;
  logic                     last_phase;

  assign last_phase = (phase_q == LAST_PHASE);
  assign done_o     = busy_q && last_phase && (bit_cnt_q == '0);
  assign busy_o     = busy_q;
  assign sdi_o      = sreg_q[BITS_PER_WORD-1];
  assign sclk_o     = sclk_q;

  always_comb begin
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    busy_d    = busy_q;
    if (load_i) begin
      sreg_d    = data_i;
      bit_cnt_d = FIRST_BIT;
      phase_d   = '0;
      busy_d    = 1'b1;
    end else if (busy_q) begin
      if (last_phase) begin
        // Shift only after the rising sclk phase so sdi is stable around the edge.
        phase_d   = '0;
        sreg_d    = {sreg_q[BITS_PER_WORD-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q - 1'b1;
        if (bit_cnt_q == '0) busy_d = 1'b0;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
    sclk_d = busy_d && (phase_d == LAST_PHASE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      phase_q   <= '0;
      busy_q    <= 1'b0;
      sclk_q    <= 1'b0;
    end else begin
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      busy_q    <= busy_d;
      sclk_q    <= sclk_d;
    end
  end

endmodule

// File: rtl/ledmatrix_scan_reader.sv
// rtl/ledmatrix_scan_reader.sv - frame-buffer read master and LED-matrix row scan engine
//
// Ports: clk, reset_n (async, active low), enable, frame_base (word address of row 0)
//        avm        - Avalon-MM read master (ledmatrix_scan_reader_if.master)
//        mtx_sdi/mtx_sclk - serial column data and shift clock
//        mtx_latch  - one-cycle latch pulse after each row is shifted
//        mtx_oe_n   - active-low display enable, low only while displaying
//        mtx_row    - currently displayed row
//        frame_done - one-cycle pulse after the last row of a frame
module ledmatrix_scan_reader
  import ledmatrix_pkg::*;
#(
  parameter int WORDS_PER_ROW = 2,
  parameter int ROWS          = 16,
  parameter int ON_CYCLES     = 256,
  parameter int ADDR_W        = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [ADDR_W-1:0]        frame_base,
  ledmatrix_scan_reader_if.master  avm,
  output logic                     mtx_sdi,
  output logic                     mtx_sclk,
  output logic                     mtx_latch,
  output logic                     mtx_oe_n,
  output logic [$clog2(ROWS)-1:0]  mtx_row,
  output logic                     frame_done
);

  localparam int ROW_W  = $clog2(ROWS);
  localparam int WORD_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int ON_W   = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_ROW - 1);
  localparam logic [ON_W-1:0]   LAST_ON   = ON_W'(ON_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
  logic [WORD_W-1:0] word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ON_W-1:0]   on_cnt_q, on_cnt_d;

  logic [ADDR_W-1:0] avm_address_q, avm_address_d;
  logic              avm_read_q, avm_read_d;
  logic              latch_q, latch_d;
  logic              oe_n_q, oe_n_d;
  logic              frame_done_q, frame_done_d;
  logic [ROW_W-1:0]  mtx_row_q, mtx_row_d;

  logic shift_load, shift_busy, shift_done;

  ledmatrix_shift_out u_shift_out (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (shift_load),
    .data_i  (avm.avm_readdata),
    .busy_o  (shift_busy),
    .done_o  (shift_done),
    .sdi_o   (mtx_sdi),
    .sclk_o  (mtx_sclk)
  );

  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    word_cnt_d   = word_cnt_q;
    base_d       = base_q;
    on_cnt_d     = on_cnt_q;
    frame_done_d = 1'b0;
    shift_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_FETCH;
          row_cnt_d  = '0;
          word_cnt_d = '0;
          base_d     = frame_base;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        // Read data is valid during this cycle (latency 1 from the FETCH strobe).
        shift_load = !shift_busy;
        state_d    = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (shift_done) begin
          if (word_cnt_q != LAST_WORD) begin
            word_cnt_d = word_cnt_q + 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        on_cnt_d = '0;
        state_d  = ST_DISPLAY;
      end
      ST_DISPLAY: begin
        if (on_cnt_q == LAST_ON) begin
          word_cnt_d = '0;
          if (row_cnt_q == LAST_ROW) begin
            frame_done_d = 1'b1;
            row_cnt_d    = '0;
            // Base is only resampled here so a frame never mixes two buffers.
            base_d       = frame_base;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
          state_d = enable ? ST_FETCH : ST_IDLE;
        end else begin
          on_cnt_d = on_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave flops in step with it.
    avm_read_d    = (state_d == ST_FETCH);
    avm_address_d = avm_read_d
                  ? base_d + ADDR_W'(row_cnt_d) * ADDR_W'(WORDS_PER_ROW) + ADDR_W'(word_cnt_d)
                  : avm_address_q;
    latch_d       = (state_d == ST_LATCH);
    oe_n_d        = (state_d != ST_DISPLAY);
    mtx_row_d     = (state_d == ST_LATCH) ? row_cnt_q : mtx_row_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      row_cnt_q     <= '0;
      word_cnt_q    <= '0;
      base_q        <= '0;
      on_cnt_q      <= '0;
      avm_address_q <= '0;
      avm_read_q    <= 1'b0;
      latch_q       <= 1'b0;
      oe_n_q        <= 1'b1;
      frame_done_q  <= 1'b0;
      mtx_row_q     <= '0;
    end else begin
      state_q       <= state_d;
      row_cnt_q     <= row_cnt_d;
      word_cnt_q    <= word_cnt_d;
      base_q        <= base_d;
      on_cnt_q      <= on_cnt_d;
      avm_address_q <= avm_address_d;
      avm_read_q    <= avm_read_d;
      latch_q       <= latch_d;
      oe_n_q        <= oe_n_d;
      frame_done_q  <= frame_done_d;
      mtx_row_q     <= mtx_row_d;
    end
  end

  assign avm.avm_address    = avm_address_q;
  assign avm.avm_chipselect = avm_read_q;
  assign avm.avm_read       = avm_read_q;
  assign avm.avm_byteenable = AVM_BYTEENABLE;
  assign mtx_latch          = latch_q;
  assign mtx_oe_n           = oe_n_q;
  assign mtx_row            = mtx_row_q;
  assign frame_done         = frame_done_q;

endmodule
